calc_seq_ctrl: RTL and testbench

- Top-level sequencer for the calculator datapath.
- Collects decimal key entry into two operands and an operator, then issues a start/done handshake to the ALU.
- Latches the result and drives the history buffer's save/equal strobes plus the display value.
- Sits between the debounced keypad decoder and the ALU/history/display blocks.

---
 rtl/calc_pkg.sv | 25 ++
 rtl/calc_digit_acc.sv | 20 ++
 rtl/calc_seq_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared key codes, ALU op encodings and sequencer states for the calculator control path.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [15:0] ERR_PATTERN = 16'hEEEE;

  typedef enum logic [2:0] {S_A, S_OP, S_B, S_EXEC, S_RES, S_ERR} state_t;

  // Operator keys are contiguous, so the op code is the offset from KEY_ADD.
  function automatic logic [1:0] key_to_op(input logic [3:0] key);
    return 2'(key - KEY_ADD);
  endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Decimal entry step: acc_out = acc_in*10 + digit, or acc_in unchanged when that exceeds MAX_OPERAND.
module calc_digit_acc #(
  parameter int DATA_W      = 16,
  parameter int MAX_OPERAND = 9999
) (
  input  logic [DATA_W-1:0] acc_in,
  input  logic [3:0]        digit,
  output logic [DATA_W-1:0] acc_out,
  output logic              acc_ok
);

  logic [DATA_W+3:0] sum;

  always_comb begin
    sum     = ({4'b0, acc_in} * (DATA_W+4)'(10)) + {{DATA_W{1'b0}}, digit};
    acc_ok  = (sum <= (DATA_W+4)'(MAX_OPERAND));
    acc_out = acc_ok ? sum[DATA_W-1:0] : acc_in;
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: key entry into A/op/B, ALU start/done handshake, result latch and history strobes.
// Define CALC_AUTO_SAVE_EN to push every successful result into history automatically.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int MAX_OPERAND = 9999,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              save_key,
  input  logic              alu_done,
  input  logic              alu_err,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [1:0]        op_code,
  output logic              alu_start,
  output logic              hist_equal,
  output logic              hist_save,
  output logic [DATA_W-1:0] hist_result,
  output logic [DATA_W-1:0] disp_val,
  output logic              err,
  output logic              busy
);

  localparam int TMO_W = $clog2(ALU_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ALU_TIMEOUT - 1);

  // states: S_A enter A | S_OP op chosen | S_B enter B | S_EXEC wait ALU | S_RES result shown | S_ERR error
  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, hist_q, hist_d, disp_q, disp_d;
  logic [1:0]        op_q, op_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              start_q, start_d, heq_q, heq_d, hsave_q, hsave_d;
  logic              err_q, err_d, busy_q, busy_d;

  logic              is_digit, is_op, is_eq, is_clr;
  logic [DATA_W-1:0] acc_out;
  logic              acc_ok;

  assign is_digit = key_valid && (key_code < KEY_ADD);
  assign is_op    = key_valid && (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
  assign is_eq    = key_valid && (key_code == KEY_EQ);
  assign is_clr   = key_valid && (key_code == KEY_CLR);

  calc_digit_acc #(
    .DATA_W      (DATA_W),
    .MAX_OPERAND (MAX_OPERAND)
  ) u_acc (
    .acc_in  ((state_q == S_B) ? b_q : a_q),
    .digit   (key_code),
    .acc_out (acc_out),
    .acc_ok  (acc_ok)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hist_d  = hist_q;
    tmo_d   = tmo_q;
    start_d = 1'b0;
    heq_d   = 1'b0;

    if (is_clr) begin
      a_d     = '0;
      b_d     = '0;
      op_d    = OP_ADD;
      state_d = S_A;
    end else begin
      case (state_q)
        S_A: begin
          if (is_digit) begin
            a_d = acc_out;
          end else if (is_op) begin
            op_d    = key_to_op(key_code);
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (is_op) begin
            op_d = key_to_op(key_code);
          end else if (is_digit) begin
            b_d     = DATA_W'(key_code);
            state_d = S_B;
          end
        end
        S_B: begin
          if (is_digit) begin
            b_d = acc_out;
          end else if (is_eq) begin
            start_d = 1'b1;
            tmo_d   = '0;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (alu_done) begin
            if (alu_err) begin
              state_d = S_ERR;
            end else begin
              hist_d  = alu_result;
              heq_d   = 1'b1;
              state_d = S_RES;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_d = S_ERR;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        S_RES: begin
          if (is_digit) begin
            a_d     = DATA_W'(key_code);
            b_d     = '0;
            state_d = S_A;
          end else if (is_op) begin
            a_d     = hist_q;
            op_d    = key_to_op(key_code);
            state_d = S_OP;
          end
        end
        S_ERR:   ;
        default: state_d = S_A;
      endcase
    end

`ifdef CALC_AUTO_SAVE_EN
    hsave_d = heq_q;
`else
    // A key in the same cycle takes precedence over a save request.
    hsave_d = (state_q == S_RES) && save_key && !key_valid;
`endif

    err_d  = (state_d == S_ERR);
    busy_d = (state_d == S_EXEC);
    case (state_d)
      S_A, S_OP:   disp_d = a_d;
      S_B, S_EXEC: disp_d = b_d;
      S_RES:       disp_d = hist_d;
      default:     disp_d = DATA_W'(ERR_PATTERN);
    endcase
  end

`ifdef CALC_AUTO_SAVE_EN
  logic unused_save_key;
  assign unused_save_key = save_key;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      hist_q  <= '0;
      disp_q  <= '0;
      tmo_q   <= '0;
      start_q <= 1'b0;
      heq_q   <= 1'b0;
      hsave_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hist_q  <= hist_d;
      disp_q  <= disp_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
      heq_q   <= heq_d;
      hsave_q <= hsave_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign operand_a   = a_q;
  assign operand_b   = b_q;
  assign op_code     = op_q;
  assign alu_start   = start_q;
  assign hist_equal  = heq_q;
  assign hist_save   = hsave_q;
  assign hist_result = hist_q;
  assign disp_val    = disp_q;
  assign err         = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl: directed scenarios plus random key sequences against a behavioural calculator model.
module tb_calc_seq_ctrl;

  localparam int T = 15;
  localparam int M_A = 0, M_OP = 1, M_B = 2, M_WAIT = 3, M_RES = 4, M_ERR = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        save_key = 1'b0;
  logic        alu_done = 1'b0;
  logic        alu_err = 1'b0;
  logic [15:0] alu_result = 16'd0;
  logic [15:0] operand_a, operand_b, hist_result, disp_val;
  logic [1:0]  op_code;
  logic        alu_start, hist_equal, hist_save, err, busy;

  calc_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .save_key(save_key), .alu_done(alu_done), .alu_err(alu_err), .alu_result(alu_result),
    .operand_a(operand_a), .operand_b(operand_b), .op_code(op_code), .alu_start(alu_start),
    .hist_equal(hist_equal), .hist_save(hist_save), .hist_result(hist_result),
    .disp_val(disp_val), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int a; int b; int op; int cyc; } start_t;
  typedef struct { int v; int cyc; } val_t;
  start_t sq[$];
  val_t   rq[$];
  val_t   vq[$];

  int n_pass = 0, n_total = 0;
  int ma = 0, mb = 0, mop = 0, mhist = 0, mode = M_A, exec_entry = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  function automatic int acc(input int v, input int d);
    return (v * 10 + d <= 9999) ? v * 10 + d : v;
  endfunction

  task automatic model_sync();
    if (mode == M_WAIT && cyc >= exec_entry + T) mode = M_ERR;
  endtask

  // Calculator rules applied to one sampled cycle of inputs; pushes expected pulses.
  task automatic model_step(input bit kv, input int k, input bit sv, input bit dv, input int r, input bit e);
    int m0;
    bit dig, opk, eqk;
    model_sync();
    m0  = mode;
    dig = kv && k < 10;
    opk = kv && k >= 10 && k <= 13;
    eqk = kv && k == 14;
    if (kv && k == 15) begin
      ma = 0; mb = 0; mop = 0; mode = M_A;
    end else begin
      case (m0)
        M_A:  if (dig) ma = acc(ma, k); else if (opk) begin mop = k - 10; mode = M_OP; end
        M_OP: if (opk) mop = k - 10; else if (dig) begin mb = k; mode = M_B; end
        M_B:  if (dig) mb = acc(mb, k);
              else if (eqk) begin
                sq.push_back(start_t'{ma, mb, mop, cyc + 1});
                exec_entry = cyc + 1;
                mode = M_WAIT;
              end
        M_WAIT: if (dv) begin
                  if (e) mode = M_ERR;
                  else begin
                    mhist = r;
                    mode = M_RES;
                    rq.push_back(val_t'{r, cyc + 1});
`ifdef CALC_AUTO_SAVE_EN
                    vq.push_back(val_t'{r, cyc + 2});
`endif
                  end
                end
        M_RES: if (dig) begin ma = k; mb = 0; mode = M_A; end
               else if (opk) begin ma = mhist; mop = k - 10; mode = M_OP; end
        default: ;
      endcase
    end
`ifndef CALC_AUTO_SAVE_EN
    if (m0 == M_RES && sv && !kv) vq.push_back(val_t'{mhist, cyc + 1});
`endif
  endtask

  task automatic check_state();
    int ed;
    model_sync();
    case (mode)
      M_A, M_OP:   ed = ma;
      M_B, M_WAIT: ed = mb;
      M_RES:       ed = mhist;
      default:     ed = 'hEEEE;
    endcase
    chk("disp_val", int'(disp_val), ed);
    chk("err", int'(err), int'(mode == M_ERR));
    chk("busy", int'(busy), int'(mode == M_WAIT));
    chk("operand_a", int'(operand_a), ma);
    chk("operand_b", int'(operand_b), mb);
    chk("op_code", int'(op_code), mop);
    chk("hist_result", int'(hist_result), mhist);
  endtask

  task automatic step(input bit kv, input int k, input bit sv, input bit dv, input int r, input bit e);
    @(negedge clk);
    key_valid = kv; key_code = 4'(k); save_key = sv;
    alu_done = dv; alu_result = 16'(r); alu_err = e;
    model_step(kv, k, sv, dv, r, e);
    @(negedge clk);
    key_valid = 1'b0; save_key = 1'b0; alu_done = 1'b0; alu_err = 1'b0;
    check_state();
  endtask

  task automatic press(input int k);          step(1, k, 0, 0, 0, 0); endtask
  task automatic save();                      step(0, 0, 1, 0, 0, 0); endtask
  task automatic respond(input int r, input bit e); step(0, 0, 0, 1, r, e); endtask

  task automatic enter_number(input int n_digits);
    for (int i = 0; i < n_digits; i++) press($urandom_range(9));
  endtask

  initial begin : monitor
    start_t s;
    val_t   v;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (alu_start) begin
          if (sq.size() == 0) chk("unexpected_alu_start", 1, 0);
          else begin
            s = sq.pop_front();
            chk("alu_start_cycle", cyc, s.cyc);
            chk("start_operand_a", int'(operand_a), s.a);
            chk("start_operand_b", int'(operand_b), s.b);
            chk("start_op_code", int'(op_code), s.op);
          end
        end
        if (hist_equal) begin
          if (rq.size() == 0) chk("unexpected_hist_equal", 1, 0);
          else begin
            v = rq.pop_front();
            chk("hist_equal_cycle", cyc, v.cyc);
            chk("equal_hist_result", int'(hist_result), v.v);
            chk("equal_disp_val", int'(disp_val), v.v);
          end
        end
        if (hist_save) begin
          if (vq.size() == 0) chk("unexpected_hist_save", 1, 0);
          else begin
            v = vq.pop_front();
            chk("hist_save_cycle", cyc, v.cyc);
            chk("save_hist_result", int'(hist_result), v.v);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    repeat (3) @(negedge clk);
    chk("reset_disp", int'(disp_val), 0);
    chk("reset_pulses", int'({alu_start, hist_equal, hist_save, err, busy}), 0);
    chk("reset_op_code", int'(op_code), 0);
    @(negedge clk) rst_n = 1'b1;
    check_state();

    // 12 + 34 = -> 46, then manual save
    press(1); press(2); press(10); press(3); press(4); press(14);
    respond(46, 0);
    save();

    // saturation at 9999, divide error, keys ignored in error, clear
    press(15);
    for (int i = 0; i < 5; i++) press(9);
    press(13); press(0); press(14);
    respond(0, 1);
    press(5); press(14);
    press(15);

    // 5 * 2 = 10, chained - 3 = 7, then key and save together drops save
    press(5); press(12); press(2); press(14); respond(10, 0);
    press(11); press(3); press(14); respond(7, 0);
    step(1, 4, 1, 0, 0, 0);

    // ALU timeout, then a late done is ignored
    press(15); press(1); press(10); press(1); press(14);
    n = 0;
    while (!err && n < 40) begin @(negedge clk); n++; end
    chk("timeout_cycle", cyc, exec_entry + T);
    check_state();
    respond(99, 0);
    press(15);

    // clear together with alu_done: clear wins
    press(7); press(12); press(8); press(14);
    step(1, 15, 0, 1, 56, 0);

    // reset while waiting on the ALU
    press(1); press(10); press(2); press(14);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_operand_a", int'(operand_a), 0);
    chk("async_rst_hist", int'(hist_result), 0);
    ma = 0; mb = 0; mop = 0; mhist = 0; mode = M_A;
    @(negedge clk) rst_n = 1'b1;
    respond(77, 0);

    // randomized sequences, occasionally chained or saved
    for (int it = 0; it < 30; it++) begin
      press(15);
      enter_number($urandom_range(6, 1));
      press(10 + $urandom_range(3));
      enter_number($urandom_range(6, 1));
      if ($urandom_range(3) == 0) press(10 + $urandom_range(3));
      press(14);
      repeat ($urandom_range(4)) @(negedge clk);
      respond($urandom_range(9999), ($urandom_range(7) == 0));
      if ($urandom_range(1) == 1) save();
      if ($urandom_range(2) == 0) begin
        press(10 + $urandom_range(3));
        enter_number($urandom_range(3, 1));
        press(14);
        respond($urandom_range(9999), 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    chk("pending_expectations", sq.size() + rq.size() + vq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
